div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit signed/unsigned divider and its sequencing FSM. Serves DIV/DIVU for the EX stage.
- EX raises start_i with operands and holds start_i high. EX derives its pipeline stall request from ready_o.
- The {remainder, quotient} result goes to EX, then to the HI/LO write path: hi = remainder, lo = quotient.
- Restoring shift-subtract algorithm, one quotient bit per cycle.

Parameters:
WIDTH, 32, operand width. Only 32 is supported by the EX and HI/LO datapath.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU)
opdata1_i  input  WIDTH  dividend
opdata2_i  input  WIDTH  divisor
start_i  input  1  divide request; held high by EX until after ready_o is seen
annul_i  input  1  abort the in-flight divide (flush)
result_o  output  2*WIDTH  {remainder[63:32], quotient[31:0]}, registered
ready_o  output  1  result valid, registered

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on the rising edge of clk.
  - rst=1 at an edge: state=FREE, cnt=0, internal dividend register=0, result_o=0, ready_o=0.
  - Reset wins over every other input, including mid-divide.
- FREE state:
  - start_i=1 and annul_i=0: capture the operands.
  - Signed mode: each negative operand is replaced by its two's complement, so the magnitude is stored.
  - Divisor==0: go to BYZERO.
  - Otherwise: go to ON with cnt=0 and dividend register = {32'b0, |op1|, 1'b0} (65 bits). ready_o=0.
  - start_i=1 with annul_i=1: ignored, stay in FREE.
- ON state:
  - annul_i=1: go to FREE with result_o=0 and ready_o=0. The partial result is discarded.
  - Otherwise, each cycle:
    - Compute diff = {1'b0, dvd[63:32]} - {1'b0, |divisor|}.
    - diff[32]=1 (negative): dvd <= dvd << 1.
    - Else: dvd <= {diff[31:0], dvd[31:0], 1'b1}.
    - cnt <= cnt+1.
  - The 32nd iteration (cnt==31) moves the FSM to END.
  - start_i dropping without annul_i does not abort; the divide completes.
- BYZERO state: next edge goes to END with dvd=0, so the result is 0/0 (no trap).
- END state:
  - Quotient = dvd[31:0]. It is negated when signed_div_i=1 and op1[31]^op2[31], using the captured operand signs.
  - Remainder = dvd[64:33]. It is negated when signed_div_i=1 and op1[31]=1.
  - Each edge in END: result_o <= {rem, quo}, ready_o <= 1.
  - start_i=0 at an END edge: go to FREE with result_o=0 and ready_o=0.
  - Annul in END: same as start_i=0.
- Latency: start accepted at edge E0 gives ready_o=1 after edge E0+33 (ON for E0+1..E0+32, first END register load at E0+33). Divide-by-zero gives ready_o=1 after edge E0+2.
- Stability: while in END with start_i high, result_o and ready_o stay constant.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no exception).
- Operand changes: once out of FREE, changes on opdata1_i/opdata2_i/signed_div_i are ignored.
- Back-to-back divides need at least one cycle in FREE, i.e. start_i low for one edge.

Decomposition:
- Shared defines.v additions:
  - DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivResultReady/DivResultNotReady.
  - DivStart/DivStop.
  - Reuse the existing RegBus, DoubleRegBus, RstEnable and EXE_DIV_OP/EXE_DIVU_OP definitions.
- No sub-module. The one-bit subtract step is inline. The EX stall and start logic lives in ex, not here.

Test Plan:
- Unsigned divide: divu 100/7, start at E0 → ready_o=1 after E0+33, result_o=0x00000002_0000000E. ready_o=0 at every earlier edge.
- Signed negative dividend: div -7/2 (0xFFFFFFF9, 0x00000002) → result_o=0xFFFFFFFF_FFFFFFFD.
- Unsigned max and signed overflow:
  - divu 0xFFFFFFFF/2 → result_o=0x00000001_7FFFFFFF.
  - div 0x80000000/0xFFFFFFFF → result_o=0x00000000_80000000.
- Divide by zero: divisor 0 → ready_o=1 after E0+2, result_o=0.
- Hold then release: start_i held 5 cycles in END → result_o stable. start_i low → FREE next edge, result_o=0, ready_o=0.
- Abort paths:
  - annul_i=1 at E0+10 → FREE next edge, ready_o=0. A new divu 9/3 then returns result_o=0x00000000_00000003.
  - rst=1 at E0+20 → all outputs 0, state FREE.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states and handshake levels.
package div_unit_pkg;
  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
endpackage

// File: rtl/div_unit.sv
// Restoring shift-subtract divider for DIV/DIVU, one quotient bit per cycle.
// Result is {remainder, quotient}; held while start_i stays high in END.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);
  localparam int CNT_W = $clog2(WIDTH);

  div_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   dvd;
  logic [WIDTH-1:0]   dsr;
  logic               neg_quo, neg_rem;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   op1_mag, op2_mag, quo, rem;
  logic               accept, last;

  assign op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  assign accept  = (start_i == DIV_START) && !annul_i;
  assign last    = (cnt == CNT_W'(WIDTH-1));

  // Upper half of the shifted dividend minus the divisor magnitude; bit WIDTH is the borrow.
  assign diff = {1'b0, dvd[2*WIDTH-1:WIDTH]} - {1'b0, dsr};
  assign quo  = neg_quo ? -dvd[WIDTH-1:0]       : dvd[WIDTH-1:0];
  assign rem  = neg_rem ? -dvd[2*WIDTH:WIDTH+1] : dvd[2*WIDTH:WIDTH+1];

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_FREE:   if (accept) state_nxt = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
      DIV_BYZERO: state_nxt = DIV_END;
      DIV_ON: begin
        if (annul_i)   state_nxt = DIV_FREE;
        else if (last) state_nxt = DIV_END;
      end
      DIV_END:    if (start_i == DIV_STOP || annul_i) state_nxt = DIV_FREE;
      default:    state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      state <= state_nxt;
      case (state)
        DIV_FREE: begin
          // Signs are latched here so later operand changes cannot flip the fix-up.
          if (accept) begin
            dsr     <= op2_mag;
            neg_quo <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem <= signed_div_i && opdata1_i[WIDTH-1];
            cnt     <= '0;
            dvd     <= {{WIDTH{1'b0}}, op1_mag, 1'b0};
          end
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
        end
        DIV_BYZERO: dvd <= '0;
        DIV_ON: begin
          if (annul_i) begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end else begin
            if (diff[WIDTH]) dvd <= {dvd[2*WIDTH-1:0], 1'b0};
            else             dvd <= {diff[WIDTH-1:0], dvd[WIDTH-1:0], 1'b1};
            cnt <= cnt + 1'b1;
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP || annul_i) begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end else begin
            result_o <= {rem, quo};
            ready_o  <= DIV_RESULT_READY;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus abort/reset sequences.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_tests = 0;
  int n_fail  = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Start a divide at the next edge (E0), scramble operands after E0, check latency and result.
  task automatic start_div(input vec_t v);
    logic early;
    @(negedge clk);
    signed_div_i = v.sgn; opdata1_i = v.op1; opdata2_i = v.op2;
    start_i = 1'b1; annul_i = 1'b0;
    tick();
    early = ready_o;
    @(negedge clk);
    signed_div_i = ~v.sgn; opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'h0000_0003;
    for (int i = 1; i < v.lat; i++) begin
      tick();
      if (ready_o) early = 1'b1;
    end
    chk({v.name, " early ready"}, 64'(early), 64'd0);
    tick();
    chk({v.name, " ready"}, 64'(ready_o), 64'd1);
    chk({v.name, " result"}, result_o, v.exp);
  endtask

  task automatic hold_release(input vec_t v);
    logic stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!ready_o || result_o !== v.exp) stable = 1'b0;
    end
    chk({v.name, " hold stable"}, 64'(stable), 64'd1);
    @(negedge clk); start_i = 1'b0;
    tick();
    chk({v.name, " release ready"}, 64'(ready_o), 64'd0);
    chk({v.name, " release result"}, result_o, 64'd0);
  endtask

  vec_t vecs[6];
  vec_t v;

  initial begin
    vecs[0] = '{"divu 100/7",     1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 33};
    vecs[1] = '{"div -7/2",       1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[2] = '{"divu max/2",     1'b0, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_7FFFFFFF, 33};
    vecs[3] = '{"div overflow",   1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33};
    vecs[4] = '{"divu by zero",   1'b0, 32'h00001234, 32'h00000000, 64'h0,                 2};
    vecs[5] = '{"div 7/-2",       1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33};

    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    tick(); tick();
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      start_div(vecs[i]);
      hold_release(vecs[i]);
    end

    // Annul at E0+10 discards the divide; a fresh divu 9/3 then works.
    v = '{"annul", 1'b0, 32'd100, 32'd7, 64'h0, 33};
    @(negedge clk);
    signed_div_i = v.sgn; opdata1_i = v.op1; opdata2_i = v.op2; start_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
    tick();
    chk("annul ready", 64'(ready_o), 64'd0);
    chk("annul result", result_o, 64'd0);
    @(negedge clk); annul_i = 1'b0;
    tick();
    v = '{"divu 9/3 after annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33};
    start_div(v);
    hold_release(v);

    // Reset at E0+20 mid-divide; outputs stay idle, then a normal divide completes.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd2; start_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk); rst = 1'b1;
    tick();
    chk("mid-divide reset ready", 64'(ready_o), 64'd0);
    chk("mid-divide reset result", result_o, 64'd0);
    @(negedge clk); rst = 1'b0; start_i = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("post-reset idle ready", 64'(ready_o), 64'd0);
    start_div(vecs[1]);
    hold_release(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
